dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data and address width.
REQ-002 SHALL have parameter WORDS, default 64, number of data memory words; addresses are word aligned and use addr[31:2].
REQ-003 SHALL have parameter MAX_BURST, default 4, the maximum number of consecutive accesses an owner keeps while the other requester waits.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 reqN (N=0 CPU data port, N=1 loader/DMA)  in  1  access request, held until served.
REQ-007 weN  in  1  write enable qualifying reqN.
REQ-008 addrN  in  DATA_W  byte address.
REQ-009 wdN  in  DATA_W  write data.
REQ-010 gntN  out  1  registered grant; an access completes in every cycle with gntN=1 and reqN=1.
REQ-011 rdN  out  DATA_W  registered read data.
REQ-012 rvalidN  out  1  one-cycle pulse; rdN is valid.
REQ-013 errN  out  1  sticky out-of-range flag.
REQ-014 mem_we  out  1  write strobe to the single-port dmem.
REQ-015 mem_a  out  DATA_W  address to dmem.
REQ-016 mem_wd  out  DATA_W  write data to dmem.
REQ-017 mem_rd  in  DATA_W  combinational read data from dmem.

Function
REQ-018 SHALL implement states IDLE, OWN0 and OWN1; gnt0=(state==OWN0) and gnt1=(state==OWN1).
REQ-019 SHALL keep a last-served pointer lsp; a tie in IDLE goes to the requester with index !lsp; lsp updates on each entry to OWNn.
REQ-020 IDLE: SHALL go to OWN0 if only req0, OWN1 if only req1, the lsp winner if both, and stay in IDLE if neither.
REQ-021 OWNn with reqn=0: SHALL go to OWN(other) if the other requester is requesting, else IDLE.
REQ-022 OWNn with reqn=1: SHALL go to OWN(other) when the beat count equals MAX_BURST-1 and the other requester is requesting; otherwise it SHALL stay.
REQ-023 The beat counter SHALL increment per completed access and clear on every state change; it SHALL saturate at MAX_BURST-1 when the owner is uncontested.
REQ-024 mem_a, mem_wd and mem_we SHALL combinationally select the owner's addrN, wdN and (weN & reqN); in IDLE they SHALL be mem_we=0, mem_a=0 and mem_wd=0.
REQ-025 A read access SHALL latch mem_rd into rdN at the completing edge, and rvalidN SHALL be 1 in the following cycle only (latency 1); a write SHALL NOT pulse rvalidN.
REQ-026 An address with addr[31:2] >= WORDS SHALL suppress mem_we, return rdN=0 with rvalidN, and set errN until reset.
REQ-027 If the owner drops req in the same cycle the other raises req, the grant SHALL switch at the next edge, with exactly one idle cycle on the bus.
REQ-028 A request that is asserted without a grant SHALL NOT produce a memory side effect.
REQ-029 rdN SHALL hold its last value between rvalid pulses.

Reset
REQ-030 While reset=0 (asynchronous), the block SHALL be in state IDLE with lsp=1, beat count 0, gntN=0, rvalidN=0, rdN=0, errN=0 and mem_we=0.
REQ-031 If reset asserts mid-burst, it SHALL abort the burst immediately and commit no write; after release, arbitration SHALL restart from IDLE.

Structure
REQ-032 Package dmem_arb_pkg SHALL hold the state enum and the default WORDS and MAX_BURST constants.
REQ-033 Two-way round-robin selection SHALL live in sub-module dmem_arb_rr (inputs req0, req1, lsp; output winner); everything else stays in dmem_arbiter.

Verification
REQ-034 Reset, then req0 write with addr0=84 and wd0=7 -> gnt0 at cycle 1, mem_we=1 with mem_a=84 for one cycle, and dmem[21]=7.
REQ-035 req0 and req1 both held with reads from the first edge -> grants OWN0 x4, OWN1 x4, OWN0 x4, and rvalid pulses alternate in groups of 4.
REQ-036 req1 read of addr 80 when dmem[20]=0x5 -> rd1=0x5 with rvalid1 exactly one cycle after the completing edge.
REQ-037 req0 write to addr 256 (word 64) -> mem_we stays 0, err0=1 and sticky, and err1 stays 0.
REQ-038 Assert reset in the second beat of a 4-write burst -> the remaining writes are not committed, all outputs are 0, and the next request is granted from IDLE.
REQ-039 req0 drops while req1 rises in the same cycle -> gnt1 is asserted at the next edge and no cycle has both grants high.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state encoding and default sizing for the dmem arbiter
package dmem_arb_pkg;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_e;
  localparam int DEF_WORDS     = 64;
  localparam int DEF_MAX_BURST = 4;
endpackage

// File: rtl/dmem_arb_rr.sv
// dmem_arb_rr: two-way round-robin pick, a tie goes to the port not served last
module dmem_arb_rr (
  input  logic req0,
  input  logic req1,
  input  logic lsp,
  output logic winner
);
  assign winner = (req0 & req1) ? !lsp : req1;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: bursty round-robin arbiter sharing one single-port dmem between CPU and loader
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int WORDS     = DEF_WORDS,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [DATA_W-1:0] addr0,
  input  logic [DATA_W-1:0] wd0,
  output logic              gnt0,
  output logic [DATA_W-1:0] rd0,
  output logic              rvalid0,
  output logic              err0,
  input  logic              req1,
  input  logic              we1,
  input  logic [DATA_W-1:0] addr1,
  input  logic [DATA_W-1:0] wd1,
  output logic              gnt1,
  output logic [DATA_W-1:0] rd1,
  output logic              rvalid1,
  output logic              err1,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);
  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);

  arb_state_e        state_q, state_d, other;
  logic              lsp_q, lsp_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        rvalid_q, rvalid_d, err_q, err_d;
  logic [DATA_W-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
  logic [DATA_W-1:0] o_addr, o_wd;
  logic              winner, idle, own, o_req, x_req, o_we, in_range, rd_acc;

  dmem_arb_rr u_rr (
    .req0   (req0),
    .req1   (req1),
    .lsp    (lsp_q),
    .winner (winner)
  );

  // Owner-side view of the request ports; an access happens only when the owner requests
  always_comb begin
    idle     = state_q == IDLE;
    own      = state_q == OWN1;
    o_req    = idle ? 1'b0 : own ? req1 : req0;
    x_req    = own ? req0 : req1;
    o_we     = own ? we1 : we0;
    o_addr   = idle ? '0 : own ? addr1 : addr0;
    o_wd     = idle ? '0 : own ? wd1 : wd0;
    in_range = o_addr[DATA_W-1:2] < (DATA_W-2)'(WORDS);
    rd_acc   = o_req & !o_we;
  end

  assign mem_we  = o_req & o_we & in_range;
  assign mem_a   = o_addr;
  assign mem_wd  = o_wd;
  assign gnt0    = state_q == OWN0;
  assign gnt1    = state_q == OWN1;
  assign rd0     = rd0_q;
  assign rd1     = rd1_q;
  assign rvalid0 = rvalid_q[0];
  assign rvalid1 = rvalid_q[1];
  assign err0    = err_q[0];
  assign err1    = err_q[1];

  // Ownership hand-off, burst counting and per-port read/error results
  always_comb begin
    other    = own ? OWN0 : OWN1;
    state_d  = idle ? ((req0 | req1) ? (winner ? OWN1 : OWN0) : IDLE)
             : !o_req ? (x_req ? other : IDLE)
             : (cnt_q == LAST && x_req) ? other : state_q;
    lsp_d    = (state_d != state_q && state_d != IDLE) ? state_d == OWN1 : lsp_q;
    cnt_d    = state_d != state_q ? '0 : (o_req && cnt_q != LAST) ? cnt_q + 1'b1 : cnt_q;
    rvalid_d = {rd_acc & own, rd_acc & !own};
    err_d    = err_q | {o_req & own & !in_range, o_req & !own & !in_range};
    rd0_d    = (rd_acc & !own) ? (in_range ? mem_rd : '0) : rd0_q;
    rd1_d    = (rd_acc & own) ? (in_range ? mem_rd : '0) : rd1_q;
  end

  // State registers; reset drops ownership at once so no write can follow it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lsp_q    <= 1'b1;
      cnt_q    <= '0;
      rvalid_q <= '0;
      err_q    <= '0;
      rd0_q    <= '0;
      rd1_q    <= '0;
    end else begin
      state_q  <= state_d;
      lsp_q    <= lsp_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rd0_q    <= rd0_d;
      rd1_q    <= rd1_d;
    end
  end
endmodule
